// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: DHT11/DHT22 single-wire transaction controller with checksum, timeout and auto-poll
module dht_sensor_ctrl #(
  parameter int CLK_FREQ_HZ    = 25000000,
  parameter int MODE           = 0,
  parameter int START_LOW_US   = 18000,
  parameter int TIMEOUT_US     = 200,
  parameter int BIT_THRESH_US  = 50,
  parameter int AUTO_PERIOD_MS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_drive_low,
  output logic        busy,
  output logic        done,
  output logic        data_valid,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [39:0] raw,
  output logic        chk_err,
  output logic        timeout_err
);
  localparam int DIV = CLK_FREQ_HZ / 1000000;
  localparam int AUTO_US = AUTO_PERIOD_MS * 1000;
  localparam logic [3:0] S_IDLE  = 4'd0, S_START = 4'd1, S_REL   = 4'd2,
                         S_RLOW  = 4'd3, S_RHIGH = 4'd4, S_BLOW  = 4'd5,
                         S_BHIGH = 4'd6, S_CHECK = 4'd7, S_DONE  = 4'd8;
  logic [3:0] state, nxt;
  logic [31:0] pre, cnt;
  logic s1, s2, tick, to, go, bad;
  logic [5:0] idx;
  logic [39:0] frame;
  logic [7:0] sum;
  logic [15:0] mag;
  assign tick = pre == 32'(DIV - 1);
  assign to = tick && cnt == 32'(TIMEOUT_US - 1);
  assign go = start || (AUTO_PERIOD_MS != 0 && tick && cnt == 32'(AUTO_US - 1));
  assign sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign bad = sum != frame[7:0];
  assign mag = {1'b0, frame[22:16], frame[15:8]};
  assign dht_drive_low = state == S_START;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign data_valid = done && !chk_err && !timeout_err;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = go ? S_START : state;
      S_START: nxt = (tick && cnt == 32'(START_LOW_US - 1)) ? S_REL : state;
      S_REL:   nxt = to ? S_DONE : !s2 ? S_RLOW : state;
      S_RLOW:  nxt = to ? S_DONE : s2 ? S_RHIGH : state;
      S_RHIGH: nxt = to ? S_DONE : !s2 ? S_BLOW : state;
      S_BLOW:  nxt = to ? S_DONE : s2 ? S_BHIGH : state;
      S_BHIGH: nxt = to ? S_DONE : s2 ? state : (idx == 6'd39) ? S_CHECK : S_BLOW;
      S_CHECK: nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pre <= '0;
      cnt <= '0;
      s1 <= 1'b1;
      s2 <= 1'b1;
      idx <= '0;
      frame <= '0;
      raw <= '0;
      humidity <= '0;
      temperature <= '0;
      chk_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // our own start pulse is known to hold the line low; keep it out of RELEASE
      s1 <= dht_drive_low | dht_in;
      s2 <= s1;
      state <= nxt;
      pre <= (nxt != state || tick) ? '0 : pre + 1;
      cnt <= (nxt != state) ? '0 : tick ? cnt + 1 : cnt;
      if (state == S_IDLE && go) begin
        chk_err <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (nxt == S_DONE && state != S_CHECK) timeout_err <= 1'b1;
      if (state == S_RHIGH) idx <= '0;
      if (state == S_BHIGH && (nxt == S_BLOW || nxt == S_CHECK)) begin
        frame <= {frame[38:0], cnt > 32'(BIT_THRESH_US)};
        idx <= idx + 1;
      end
      if (state == S_CHECK) begin
        raw <= frame;
        chk_err <= bad;
        if (!bad) begin
          humidity <= (MODE != 0) ? frame[39:24] : {8'd0, frame[39:32]};
          temperature <= (MODE != 0) ? (frame[23] ? -mag : mag) : {8'd0, frame[23:16]};
        end
      end
    end
  end
endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb_dht_sensor_ctrl: scoreboard bench with a DHT sensor model for DHT11, DHT22 and auto-poll instances
module tb_dht_sensor_ctrl;
  typedef struct {
    int i;
    logic [15:0] h;
    logic [15:0] t;
    logic [39:0] r;
    logic dv;
    logic ce;
    logic te;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st[3];
  logic sen[3];
  wire line[3];
  wire drv[3], busy[3], done[3], dv[3], ce[3], te[3];
  wire [15:0] hum[3], tmp[3];
  wire [39:0] raw[3];
  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int auto_n = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : pad
    assign line[g] = drv[g] ? 1'b0 : sen[g];
  end
  dht_sensor_ctrl #(.CLK_FREQ_HZ(2000000), .MODE(0), .START_LOW_US(100), .TIMEOUT_US(200),
    .BIT_THRESH_US(50), .AUTO_PERIOD_MS(0)) u11 (
    .clk(clk), .rst(rst), .start(st[0]), .dht_in(line[0]), .dht_drive_low(drv[0]), .busy(busy[0]),
    .done(done[0]), .data_valid(dv[0]), .humidity(hum[0]), .temperature(tmp[0]), .raw(raw[0]),
    .chk_err(ce[0]), .timeout_err(te[0]));
  dht_sensor_ctrl #(.CLK_FREQ_HZ(2000000), .MODE(1), .START_LOW_US(100), .TIMEOUT_US(200),
    .BIT_THRESH_US(50), .AUTO_PERIOD_MS(0)) u22 (
    .clk(clk), .rst(rst), .start(st[1]), .dht_in(line[1]), .dht_drive_low(drv[1]), .busy(busy[1]),
    .done(done[1]), .data_valid(dv[1]), .humidity(hum[1]), .temperature(tmp[1]), .raw(raw[1]),
    .chk_err(ce[1]), .timeout_err(te[1]));
  dht_sensor_ctrl #(.CLK_FREQ_HZ(2000000), .MODE(0), .START_LOW_US(100), .TIMEOUT_US(200),
    .BIT_THRESH_US(50), .AUTO_PERIOD_MS(1)) uap (
    .clk(clk), .rst(rst), .start(st[2]), .dht_in(line[2]), .dht_drive_low(drv[2]), .busy(busy[2]),
    .done(done[2]), .data_valid(dv[2]), .humidity(hum[2]), .temperature(tmp[2]), .raw(raw[2]),
    .chk_err(ce[2]), .timeout_err(te[2]));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask
  task automatic push(input int i, input logic [15:0] h, input logic [15:0] t, input logic [39:0] r,
                      input logic v, input logic c, input logic o);
    exp_t x;
    x.i = i; x.h = h; x.t = t; x.r = r; x.dv = v; x.ce = c; x.te = o;
    q.push_back(x);
  endtask
  task automatic us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask
  task automatic pulse(input int i);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask
  // sensor model: answers the host start pulse, then sends 40 bits MSB-first
  task automatic send(input int i, input logic [39:0] f, input int cut, input int stb);
    int n = 0;
    for (int k = 0; k < 1000 && !drv[i]; k++) @(negedge clk);
    while (drv[i] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("start_low_len", n, 200);
    us(30); sen[i] = 1'b0; us(80); sen[i] = 1'b1; us(80);
    for (int j = 0; j < 40; j++) begin
      sen[i] = 1'b0; us(50); sen[i] = 1'b1;
      if (j == stb) pulse(i);
      if (j == cut) begin
        us(10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy[i], 0);
        chk("rst_drive", drv[i], 0);
        chk("rst_done", done[i], 0);
        chk("rst_hum", hum[i], 0);
        chk("rst_raw", raw[i], 0);
        rst = 1'b0;
        return;
      end
      us(f[39-j] ? 70 : 26);
    end
    sen[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, input int max);
    int k = 0;
    while (!done[i] && k < max) begin
      k++;
      @(negedge clk);
    end
    chk("done_seen", done[i], 1);
    sen[i] = 1'b1;
    @(negedge clk);
    chk("busy_drop", busy[i], 0);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (done[i]) begin
      chk("done_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("inst", i, e.i);
        chk("humidity", hum[i], e.h);
        chk("temperature", tmp[i], e.t);
        chk("raw", raw[i], e.r);
        chk("data_valid", dv[i], e.dv);
        chk("chk_err", ce[i], e.ce);
        chk("timeout_err", te[i], e.te);
      end
    end
    if (done[2]) begin
      auto_n++;
      chk("auto_te", te[2], 1);
      chk("auto_dv", dv[2], 0);
    end
  end
  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      sen[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", busy[0], 0);
    chk("reset_drive", drv[0], 0);
    chk("reset_done", done[0], 0);
    chk("reset_hum", hum[1], 0);
    chk("reset_raw", raw[0], 0);
    chk("reset_errs", {ce[0], te[0]}, 0);
    rst = 1'b0;
    @(negedge clk);
    push(0, 16'h0037, 16'h0018, 40'h370018004F, 1, 0, 0);
    pulse(0); send(0, 40'h370018004F, 99, 99); wait_done(0, 100);
    push(0, 16'h0037, 16'h0018, 40'h3700180050, 0, 1, 0);
    pulse(0); send(0, 40'h3700180050, 99, 99); wait_done(0, 100);
    chk("chk_err_sticky", ce[0], 1);
    push(0, 16'h0037, 16'h0018, 40'h3700180050, 0, 0, 1);
    pulse(0); wait_done(0, 1500);
    chk("timeout_sticky", te[0], 1);
    push(0, 16'h002A, 16'h001B, 40'h2A001B0045, 1, 0, 0);
    pulse(0);
    chk("te_cleared", te[0], 0);
    chk("busy_set", busy[0], 1);
    send(0, 40'h2A001B0045, 99, 10); wait_done(0, 100);
    push(1, 16'h028C, 16'hFF9B, 40'h028C806573, 1, 0, 0);
    pulse(1); send(1, 40'h028C806573, 99, 99); wait_done(1, 100);
    push(1, 16'h0190, 16'h00FA, 40'h019000FA8B, 1, 0, 0);
    pulse(1); send(1, 40'h019000FA8B, 99, 99); wait_done(1, 100);
    pulse(0); send(0, 40'h370018004F, 20, 99);
    repeat (200) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    n = 0;
    while (!done[2] && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("auto_done_seen", done[2], 1);
    n = 0;
    while (!drv[2] && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("auto_gap", n >= 1995 && n <= 2005, 1);
    chk("auto_repeat", auto_n >= 2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dht_sensor_ctrl.md
Name: dht_sensor_ctrl

Overview:
Complete single-wire DHT11/DHT22 transaction controller: host start pulse, sensor response handshake, 40-bit frame capture, checksum check, timeout detection and optional periodic auto-polling.
Parametrised in clock frequency, sensor mode and all protocol timings.
Sits between the board-level open-drain pad (tristate in top) and downstream display/UART logic.
Replaces the separate start/receive blocks and the external frequency divider.

Parameters:
CLK_FREQ_HZ, 25000000, system clock frequency; integer multiple of 1 MHz, ≥1 MHz.
MODE, 0, 0 = DHT11, 1 = DHT22.
START_LOW_US, 18000, host start-low duration in µs (use 1000 for DHT22).
TIMEOUT_US, 200, maximum duration of any sensor-driven phase before abort.
BIT_THRESH_US, 50, a high pulse longer than this decodes as 1; otherwise 0.
AUTO_PERIOD_MS, 0, auto-poll period in ms; 0 disables auto-polling.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request; ignored while busy
dht_in  input  1  sampled data line (asynchronous)
dht_drive_low  output  1  1 = pad drives 0; 0 = released (pull-up)
busy  output  1  transaction in progress
done  output  1  single-cycle pulse at end of every transaction (success or error)
data_valid  output  1  single-cycle pulse, coincident with done, only when frame is good
humidity  output  16  decoded humidity
temperature  output  16  decoded temperature, signed
raw  output  40  last captured frame, byte0 in [39:32]
chk_err  output  1  sticky until next start: checksum mismatch
timeout_err  output  1  sticky until next start: phase timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; line released. rst mid-transaction aborts immediately: next cycle line released, busy=0, no done pulse.
- dht_in passes through a 2-flop synchroniser before use. All timing is derived from an internal 1 µs tick: prescaler counts 0..CLK_FREQ_HZ/1e6-1.
- Phase counter: clears on every state entry and counts ticks; resolution ±1 µs.
- IDLE: start, or auto-poll counter expiry, moves to START_LOW. Entering START_LOW sets busy=1 and clears chk_err/timeout_err.
- START_LOW: dht_drive_low=1 for START_LOW_US ticks, then → RELEASE.
- RELEASE: line released; wait for synced low → RESP_LOW.
- RESP_LOW: wait for high → RESP_HIGH.
- RESP_HIGH: wait for low → BIT_LOW; bit index = 0.
- BIT_LOW: wait for high → BIT_HIGH.
- BIT_HIGH: on falling edge, shift in (count > BIT_THRESH_US) MSB-first and increment bit index. After bit 39 → CHECK; otherwise → BIT_LOW.
- Timeouts: in RELEASE through BIT_HIGH, phase counter reaching TIMEOUT_US → DONE with timeout_err=1. raw, humidity and temperature are not updated.
- CHECK (1 cycle):
  - raw ← frame.
  - chk_err = (byte4 != (byte0+byte1+byte2+byte3) mod 256).
  - If chk_err=0, update humidity/temperature:
    - MODE 0: humidity = {8'd0, byte0}; temperature = {8'd0, byte2}.
    - MODE 1: humidity = {byte0, byte1} in tenths %RH; temperature = {byte2[6:0], byte3} as tenths °C, two's-complement negated if byte2[7]=1.
- DONE (1 cycle): done=1; data_valid = !chk_err && !timeout_err; busy=0 on the following cycle; → IDLE.
- Latency: done asserts exactly 1 cycle after the final falling edge is detected; detection lags the pad by 2 cycles (synchroniser).
- Auto-poll: a ms counter runs only in IDLE and restarts at every DONE; it fires at AUTO_PERIOD_MS. If start and auto-fire coincide, a single transaction is launched.
- start during busy: dropped, with no queueing.

Test Plan:
- Nominal DHT11: CLK_FREQ_HZ=2e6, START_LOW_US=100. Sensor model sends 0x37,0x00,0x18,0x00,0x4F → dht_drive_low high for exactly 200 clk; done and data_valid pulse once; humidity=0x0037; temperature=0x0018; raw=0x370018004F.
- Checksum error: same frame with byte4=0x50 → done=1, data_valid=0, chk_err=1; humidity/temperature retain previous values; raw=0x3700180050.
- No response: line stays high after release → after TIMEOUT_US (200 µs), done=1, timeout_err=1, busy drops; errors clear on next start.
- DHT22 negative: MODE=1, frame 0x02,0x8C,0x80,0x65,0x73 → humidity=0x028C (65.2%), temperature=0xFF9B (−10.1 °C), data_valid=1.
- Robustness: start pulsed mid-frame → ignored, frame completes normally; rst asserted during BIT_HIGH → next cycle busy=0, dht_drive_low=0, outputs 0, no done pulse.
- Auto-poll: AUTO_PERIOD_MS=1, no start → successive START_LOW entries 1 ms after each DONE; sensor silent → repeated timeout_err done pulses.
